// File: rtl/frame_builder_if.sv
// Command, payload and framed-stream bundle between a traffic source and frame_builder.
// Latency: none, this file only declares wires.
// Backpressure: cmd_ready/pld_ready flow back to the source; the framed stream has none.
interface frame_builder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_mask;
    logic [2:0]  cmd_len_m1;
    logic        pld_valid;
    logic        pld_ready;
    logic [15:0] pld_data;
    logic [15:0] data_out;
    logic        sof;
    logic        eof;
    logic        busy;
`ifdef FRAME_BUILDER_CRC_INJ_EN
    logic        crc_inj;

    // Source side: offers commands and payload, watches the stream.
    modport master (
        output cmd_valid, cmd_mask, cmd_len_m1, crc_inj, pld_valid, pld_data,
        input  cmd_ready, pld_ready, data_out, sof, eof, busy
    );

    // Builder side.
    modport slave (
        input  cmd_valid, cmd_mask, cmd_len_m1, crc_inj, pld_valid, pld_data,
        output cmd_ready, pld_ready, data_out, sof, eof, busy
    );
`else
    // Source side: offers commands and payload, watches the stream.
    modport master (
        output cmd_valid, cmd_mask, cmd_len_m1, pld_valid, pld_data,
        input  cmd_ready, pld_ready, data_out, sof, eof, busy
    );

    // Builder side.
    modport slave (
        input  cmd_valid, cmd_mask, cmd_len_m1, pld_valid, pld_data,
        output cmd_ready, pld_ready, data_out, sof, eof, busy
    );
`endif
endinterface

// File: rtl/frame_builder.sv
// Frame builder: buffers one command plus 1..8 payload words, then emits HEADER, CTRL, payload, CRC-16.
// Latency: HEADER on data_out 2 cycles after the last payload handshake; the frame then streams gap-free.
// Backpressure: cmd_ready only in IDLE, pld_ready only in LOAD; optional CRC inversion via FRAME_BUILDER_CRC_INJ_EN.
module frame_builder #(
    parameter logic [15:0] HEADER     = 16'hE0E0,
    parameter logic [15:0] IDLE_WORD  = 16'h0000,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic [15:0] CRC_INIT   = 16'hFFFF
) (
    input  logic           clk_in,
    input  logic           rst,
    frame_builder_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEAD,
        S_CTRL,
        S_DATA,
        S_CRC,
        S_GAP
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [7:0]  mask_q;
    logic [2:0]  len_q;
    logic [2:0]  wr_ptr_q;
    logic [2:0]  rd_ptr_q;
    logic [3:0]  gap_q;
    logic [15:0] crc_q;
    logic [15:0] pbuf [0:7];

    logic [15:0] data_q;
    logic        sof_q;
    logic        eof_q;

    logic [15:0] out_d;
    logic        sof_d;
    logic        eof_d;
    logic        cmd_ready_c;
    logic        pld_ready_c;
    logic        busy_c;

    logic        cmd_hs;
    logic        pld_hs;
    logic [15:0] ctrl_word;
    logic        inj_q;

    // CRC-16/CCITT-FALSE step over one 16-bit word, MSB first.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [15:0] d);
        logic [15:0] c;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ d[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    assign cmd_hs    = bus.cmd_valid & cmd_ready_c;
    assign pld_hs    = bus.pld_valid & pld_ready_c;
    assign ctrl_word = {5'b00000, len_q, mask_q};

    // State register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: LOAD holds until the last payload word, DATA until the last buffered word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cmd_hs) state_d = S_LOAD;
            S_LOAD: if (pld_hs && (wr_ptr_q == len_q)) state_d = S_HEAD;
            S_HEAD: state_d = S_CTRL;
            S_CTRL: state_d = S_DATA;
            S_DATA: if (rd_ptr_q == len_q) state_d = S_CRC;
            S_CRC:  state_d = S_GAP;
            S_GAP:  if (gap_q <= 4'd1) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Per-state output decode; the stream word is registered one cycle later.
    always_comb begin
        out_d       = IDLE_WORD;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        cmd_ready_c = 1'b0;
        pld_ready_c = 1'b0;
        busy_c      = 1'b1;
        case (state_q)
            S_IDLE: begin
                // Held low while reset is asserted so nothing handshakes during reset.
                cmd_ready_c = ~rst;
                busy_c      = 1'b0;
            end
            S_LOAD: pld_ready_c = 1'b1;
            S_HEAD: begin
                out_d = HEADER;
                sof_d = 1'b1;
            end
            S_CTRL: out_d = ctrl_word;
            S_DATA: out_d = pbuf[rd_ptr_q];
            S_CRC: begin
                out_d = crc_q ^ {16{inj_q}};
                eof_d = 1'b1;
            end
            default: out_d = IDLE_WORD;
        endcase
    end

    // Registered stream outputs; reset forces the idle word and drops any partial frame.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            data_q <= IDLE_WORD;
            sof_q  <= 1'b0;
            eof_q  <= 1'b0;
        end else begin
            data_q <= out_d;
            sof_q  <= sof_d;
            eof_q  <= eof_d;
        end
    end

    // Command capture: mask and length are frozen for the whole frame.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            mask_q <= 8'h00;
            len_q  <= 3'd0;
        end else if (cmd_hs) begin
            mask_q <= bus.cmd_mask;
            len_q  <= bus.cmd_len_m1;
        end
    end

`ifdef FRAME_BUILDER_CRC_INJ_EN
    // Injection request is taken with the command so it affects that frame only.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            inj_q <= 1'b0;
        end else if (cmd_hs) begin
            inj_q <= bus.crc_inj;
        end
    end
`else
    assign inj_q = 1'b0;
`endif

    // Write pointer walks the buffer during LOAD; restarts on every accepted command.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 3'd0;
        end else if (cmd_hs) begin
            wr_ptr_q <= 3'd0;
        end else if (pld_hs) begin
            wr_ptr_q <= wr_ptr_q + 3'd1;
        end
    end

    // Payload storage; contents are only meaningful up to the latched length, so no reset.
    always_ff @(posedge clk_in) begin
        if (pld_hs) begin
            pbuf[wr_ptr_q] <= bus.pld_data;
        end
    end

    // Read pointer: zeroed while CTRL goes out, advanced per DATA word.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= 3'd0;
        end else if (state_q == S_CTRL) begin
            rd_ptr_q <= 3'd0;
        end else if (state_q == S_DATA) begin
            rd_ptr_q <= rd_ptr_q + 3'd1;
        end
    end

    // Inter-frame gap counter: armed while the CRC word goes out, counted down in GAP.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            gap_q <= 4'd0;
        end else if (state_q == S_CRC) begin
            gap_q <= 4'(GAP_CYCLES);
        end else if ((state_q == S_GAP) && (gap_q != 4'd0)) begin
            gap_q <= gap_q - 4'd1;
        end
    end

    // CRC accumulates CTRL and payload words in the same cycle they are selected for output.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            crc_q <= 16'h0000;
        end else begin
            case (state_q)
                S_HEAD:  crc_q <= CRC_INIT;
                S_CTRL:  crc_q <= crc16_word(crc_q, ctrl_word);
                S_DATA:  crc_q <= crc16_word(crc_q, pbuf[rd_ptr_q]);
                default: crc_q <= crc_q;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.pld_ready = pld_ready_c;
    assign bus.busy      = busy_c;
    assign bus.data_out  = data_q;
    assign bus.sof       = sof_q;
    assign bus.eof       = eof_q;

endmodule
